// File: rtl/move_request_ctrl.sv
// rtl/move_request_ctrl.sv - keyboard move request FSM with debounce and move counter
// Build option: MOVE_REQUEST_WASD_EN adds WASD keys to the arrow-key decode.
module move_request_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  keycode,
    input  logic        move_done,
    input  logic        clear,
    output logic        move_valid,
    output logic [1:0]  move_dir,
    output logic        busy,
    output logic        count_load,
    output logic [11:0] count_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RELEASE} state_t;

    state_t      state, state_next;
    logic [7:0]  prev_key;
    logic [7:0]  deb_cnt, deb_next;
    logic [1:0]  dir_next;
    logic [11:0] count_next;
    logic        load_next;
    logic        cur_move, prev_move;
    logic [1:0]  cur_dir;

    function automatic logic key_is_move(input logic [7:0] code);
        case (code)
            8'h52, 8'h51, 8'h50, 8'h4F: key_is_move = 1'b1;
`ifdef MOVE_REQUEST_WASD_EN
            8'h1A, 8'h16, 8'h04, 8'h07: key_is_move = 1'b1;
`endif
            default:                    key_is_move = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] key_dir(input logic [7:0] code);
        case (code)
            8'h51:   key_dir = 2'b01;
            8'h50:   key_dir = 2'b10;
            8'h4F:   key_dir = 2'b11;
`ifdef MOVE_REQUEST_WASD_EN
            8'h16:   key_dir = 2'b01;
            8'h04:   key_dir = 2'b10;
            8'h07:   key_dir = 2'b11;
`endif
            default: key_dir = 2'b00;
        endcase
    endfunction

    assign cur_move   = key_is_move(keycode);
    assign prev_move  = key_is_move(prev_key);
    assign cur_dir    = key_dir(keycode);
    assign move_valid = (state == ISSUE);
    assign busy       = (state == ISSUE) || (state == WAIT_DONE);

    always_comb begin
        state_next = state;
        dir_next   = move_dir;
        count_next = count_out;
        load_next  = 1'b0;
        deb_next   = 8'd0;
        case (state)
            IDLE: begin
                // Edge qualification: a key already down when IDLE is entered never fires.
                if (cur_move && !prev_move) begin
                    dir_next   = cur_dir;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (move_done) begin
                    count_next = count_out + 12'd1;
                    load_next  = 1'b1;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (cur_move)
                    deb_next = 8'd0;
                else if (deb_cnt == 8'(DEBOUNCE_CYCLES - 1))
                    state_next = IDLE;
                else
                    deb_next = deb_cnt + 8'd1;
            end
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = IDLE;
            dir_next   = move_dir;
            count_next = 12'h000;
            load_next  = 1'b1;
            deb_next   = 8'd0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            prev_key   <= 8'h00;
            deb_cnt    <= 8'd0;
            move_dir   <= 2'b00;
            count_out  <= 12'h000;
            count_load <= 1'b0;
        end else begin
            state      <= state_next;
            prev_key   <= keycode;
            deb_cnt    <= deb_next;
            move_dir   <= dir_next;
            count_out  <= count_next;
            count_load <= load_next;
        end
    end

endmodule
